// File: rtl/motor_pkg.sv
// Shared definitions for the remote-command motor controller: command codes,
// H-bridge drive patterns, FSM state encoding and command decode helpers.
package motor_pkg;

    localparam logic [2:0] CMD_STOP  = 3'd0;
    localparam logic [2:0] CMD_FWD   = 3'd1;
    localparam logic [2:0] CMD_BWD   = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;

    // {L_IN1, L_IN2, R_IN1, R_IN2}
    localparam logic [3:0] PAT_STOP  = 4'b0000;
    localparam logic [3:0] PAT_FWD   = 4'b1010;
    localparam logic [3:0] PAT_BWD   = 4'b0101;
    localparam logic [3:0] PAT_LEFT  = 4'b0110;
    localparam logic [3:0] PAT_RIGHT = 4'b1001;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        RAMP_DOWN = 2'd1,
        DEAD      = 2'd2
    } state_t;

    // Codes 5..7 are not commands and must leave the controller untouched.
    function automatic logic cmd_known(input logic [2:0] c);
        return (c <= CMD_RIGHT);
    endfunction

    function automatic logic [3:0] cmd_pattern(input logic [2:0] c);
        case (c)
            CMD_FWD:   return PAT_FWD;
            CMD_BWD:   return PAT_BWD;
            CMD_LEFT:  return PAT_LEFT;
            CMD_RIGHT: return PAT_RIGHT;
            default:   return PAT_STOP;
        endcase
    endfunction

endpackage

// File: rtl/motor_cmd_ctrl_pwm_gen.sv
// PWM generator: counter running 0 .. 2^PWM_W-2 (period 2^PWM_W-1) compared
// against duty, so duty 0 is constant low and duty 2^PWM_W-1 constant high.
module pwm_gen #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm
);

    localparam logic [PWM_W-1:0] CNT_MAX = {{(PWM_W-1){1'b1}}, 1'b0};

    logic [PWM_W-1:0] cnt;

    // Free-running period counter, wrapping one short of all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == CNT_MAX)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign pwm = (cnt < duty);

endmodule

// File: rtl/motor_cmd_ctrl.sv
// Remote-command motor controller: decodes 3-bit commands into H-bridge
// patterns, ramps the PWM duty, and inserts a ramp-down plus dead time before
// any direction change. Optional command watchdog: define CMD_WATCHDOG_EN.
module motor_cmd_ctrl
    import motor_pkg::*;
#(
    parameter int PWM_W     = 8,
    parameter int RAMP_DIV  = 50000,
    parameter int RAMP_STEP = 4,
    parameter int DEAD_CYC  = 1000,
    parameter int WDOG_CYC  = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       cmd,
    input  logic             cmd_valid,
    input  logic [PWM_W-1:0] speed,
    output logic [3:0]       motor,
    output logic [1:0]       pwm,
    output logic             busy,
    output logic             wdog_trip
);

    localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [PWM_W:0] STEP_X = (PWM_W+1)'(RAMP_STEP);

    state_t            state;
    logic [3:0]        pending;
    logic [3:0]        active;
    logic [3:0]        pend_nxt;
    logic [PWM_W-1:0]  duty;
    logic [PWM_W-1:0]  target;
    logic [DIV_W-1:0]  div_cnt;
    logic [DEAD_W-1:0] dead_cnt;
    logic              tick;
    logic              cmd_ok;
    logic              wdog_fire;
    logic              pwm_bit;

    // One step toward tgt, landing exactly on tgt when closer than a step.
    function automatic logic [PWM_W-1:0] ramp_toward(input logic [PWM_W-1:0] cur,
                                                     input logic [PWM_W-1:0] tgt);
        logic [PWM_W:0] diff;
        if (cur < tgt) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            return (diff > STEP_X) ? cur + STEP_X[PWM_W-1:0] : tgt;
        end else if (cur > tgt) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            return (diff > STEP_X) ? cur - STEP_X[PWM_W-1:0] : tgt;
        end
        return cur;
    endfunction

    assign cmd_ok = cmd_valid && cmd_known(cmd);
    // A command arriving this cycle already counts, so it wins over the
    // stored value at a DEAD exit or a direct load.
    assign pend_nxt = cmd_ok ? cmd_pattern(cmd) : (wdog_fire ? PAT_STOP : pending);

`ifdef CMD_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_cnt;
    logic            wdog_hit;

    assign wdog_hit  = (wdog_cnt == WD_W'(WDOG_CYC - 1));
    assign wdog_fire = !cmd_ok && wdog_hit;

    // Silence counter: any valid command restarts it; expiry requests a stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt  <= '0;
            wdog_trip <= 1'b0;
        end else if (cmd_ok) begin
            wdog_cnt  <= '0;
            wdog_trip <= 1'b0;
        end else if (wdog_hit) begin
            wdog_cnt  <= '0;
            wdog_trip <= 1'b1;
        end else begin
            wdog_cnt  <= wdog_cnt + 1'b1;
            wdog_trip <= 1'b0;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign wdog_trip = 1'b0;
`endif

    // Pending pattern register: last valid command (or watchdog stop).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= PAT_STOP;
        else
            pending <= pend_nxt;
    end

    // Free-running ramp divider producing one tick every RAMP_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (div_cnt == DIV_W'(RAMP_DIV - 1));

    // Target is the requested speed only while driving a non-stop pattern.
    always_comb begin
        target = '0;
        if (state == RUN && active != PAT_STOP)
            target = speed;
    end

    // Duty moves toward the target one step per ramp tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            duty <= '0;
        else if (tick)
            duty <= ramp_toward(duty, target);
    end

    // Direction FSM: direct load from standstill, otherwise ramp down then dead time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            active   <= PAT_STOP;
            motor    <= PAT_STOP;
            dead_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (pend_nxt != active) begin
                        if (active == PAT_STOP && duty == '0) begin
                            active <= pend_nxt;
                            motor  <= pend_nxt;
                        end else begin
                            state <= RAMP_DOWN;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (duty == '0) begin
                        state    <= DEAD;
                        motor    <= PAT_STOP;
                        dead_cnt <= '0;
                    end
                end
                DEAD: begin
                    if (dead_cnt == DEAD_W'(DEAD_CYC - 1)) begin
                        state  <= RUN;
                        active <= pend_nxt;
                        motor  <= pend_nxt;
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign busy = (state != RUN) || (duty != target);

    pwm_gen #(
        .PWM_W (PWM_W)
    ) u_pwm_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty),
        .pwm   (pwm_bit)
    );

    assign pwm = {2{pwm_bit}};

endmodule

// File: tb/tb_motor_cmd_ctrl.sv
// Self-checking bench for motor_cmd_ctrl. Build with CMD_WATCHDOG_EN defined
// to exercise the watchdog; the watchdog scenario adapts its expectations.
module tb_motor_cmd_ctrl;

    localparam int PWM_W     = 4;
    localparam int RAMP_DIV  = 2;
    localparam int RAMP_STEP = 4;
    localparam int DEAD_CYC  = 3;
    localparam int WDOG_CYC  = 100;
    localparam int SPEED     = 12;

    localparam logic [3:0] P_STOP = 4'b0000;
    localparam logic [3:0] P_FWD  = 4'b1010;
    localparam logic [3:0] P_BWD  = 4'b0101;
    localparam logic [3:0] P_LEFT = 4'b0110;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       cmd = 3'd0;
    logic             cmd_valid = 1'b0;
    logic [PWM_W-1:0] speed = PWM_W'(SPEED);
    logic [3:0]       motor;
    logic [1:0]       pwm;
    logic             busy;
    logic             wdog_trip;

    int checks = 0;
    int errors = 0;

    int         duty_log[$];
    logic [3:0] motor_log[$];
    logic       busy_log[$];
    logic       trip_log[$];
    logic [1:0] pwm_log[$];
    int         chg_q[$];
    int         chg_idx[$];
    int         exp_q[$];
    int         model_duty = 0;

    motor_cmd_ctrl #(
        .PWM_W     (PWM_W),
        .RAMP_DIV  (RAMP_DIV),
        .RAMP_STEP (RAMP_STEP),
        .DEAD_CYC  (DEAD_CYC),
        .WDOG_CYC  (WDOG_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .speed     (speed),
        .motor     (motor),
        .pwm       (pwm),
        .busy      (busy),
        .wdog_trip (wdog_trip)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish (checks %0d)", checks);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic record(input int n);
        duty_log.delete(); motor_log.delete(); busy_log.delete();
        trip_log.delete(); pwm_log.delete();
        repeat (n) begin
            step();
            duty_log.push_back(int'(dut.duty));
            motor_log.push_back(motor);
            busy_log.push_back(busy);
            trip_log.push_back(wdog_trip);
            pwm_log.push_back(pwm);
        end
    endtask

    // Reference: duty values visited when ramping from one level to another.
    function automatic void model_ramp(input int from, input int to);
        int d = from;
        while (d != to) begin
            if (d < to) d = (to - d > RAMP_STEP) ? d + RAMP_STEP : to;
            else        d = (d - to > RAMP_STEP) ? d - RAMP_STEP : to;
            exp_q.push_back(d);
        end
    endfunction

    function automatic void extract_changes(input int d0);
        int prev = d0;
        chg_q.delete(); chg_idx.delete();
        foreach (duty_log[i]) begin
            if (duty_log[i] != prev) begin
                chg_q.push_back(duty_log[i]);
                chg_idx.push_back(i);
                prev = duty_log[i];
            end
        end
    endfunction

    function automatic bit seq_equal();
        if (chg_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (chg_q[i] != exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q2s(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    task automatic test_reset();
        int bad_pwm = 0;
        rst_n = 1'b0;
        cmd   = 3'd1;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = ~cmd_valid;
            step();
            checks++;
            if (motor !== P_STOP || pwm !== 2'b00 || busy !== 1'b0 || wdog_trip !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold motor=%b pwm=%b busy=%b trip=%b required 0000/00/0/0",
                         motor, pwm, busy, wdog_trip);
            end
        end
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        record(15);
        foreach (pwm_log[i]) if (pwm_log[i] !== 2'b00 || motor_log[i] !== P_STOP || busy_log[i] !== 1'b0) bad_pwm++;
        checks++;
        if (bad_pwm !== 0) begin
            errors++;
            $display("FAIL idle_after_reset %0d cycles with pwm/motor/busy nonzero, required 0", bad_pwm);
        end
    endtask

    task automatic test_start();
        int bad = 0;
        int highs = 0;
        speed = PWM_W'(SPEED);
        send_cmd(3'd1);
        checks++;
        if (motor !== P_FWD) begin
            errors++;
            $display("FAIL start_direct_load motor=%b required %b", motor, P_FWD);
        end
        record(20);
        extract_changes(0);
        exp_q.delete();
        model_ramp(0, SPEED);
        checks++;
        if (!seq_equal()) begin
            errors++;
            $display("FAIL start_ramp duty seq=%s required %s", q2s(chg_q), q2s(exp_q));
        end
        for (int i = 1; i < chg_idx.size(); i++)
            if (chg_idx[i] - chg_idx[i-1] != RAMP_DIV) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL start_tick_spacing %0d gaps differ from %0d cycles", bad, RAMP_DIV);
        end
        bad = 0;
        foreach (busy_log[i]) if (busy_log[i] !== (duty_log[i] != SPEED)) bad++;
        checks++;
        if (bad !== 0 || busy_log[19] !== 1'b0) begin
            errors++;
            $display("FAIL start_busy %0d cycles busy wrong, final busy=%b required 0", bad, busy_log[19]);
        end
        record(15);
        bad = 0;
        foreach (pwm_log[i]) begin
            if (pwm_log[i] == 2'b11) highs++;
            else if (pwm_log[i] != 2'b00) bad++;
        end
        checks++;
        if (highs !== SPEED || bad !== 0) begin
            errors++;
            $display("FAIL start_pwm_duty high=%0d split=%0d required high=%0d split=0", highs, bad, SPEED);
        end
        model_duty = SPEED;
    endtask

    task automatic test_invalid();
        for (int k = 0; k < 6; k++) begin
            int bad = 0;
            logic [2:0] c;
            c = (k < 3) ? 3'(5 + k) : 3'($urandom_range(5, 7));
            send_cmd(c);
            record(4);
            foreach (motor_log[i])
                if (motor_log[i] !== P_FWD || duty_log[i] != model_duty || busy_log[i] !== 1'b0) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL invalid_cmd code=%0d %0d cycles disturbed (motor=%b duty=%0d busy=%b) required %b/%0d/0",
                         c, bad, motor_log[3], duty_log[3], busy_log[3], P_FWD, model_duty);
            end
        end
    endtask

    task automatic test_speed_random();
        for (int it = 0; it < 8; it++) begin
            int tgt;
            int cnt;
            if (it == 0)      tgt = (1 << PWM_W) - 1;
            else if (it == 1) tgt = 0;
            else if (it == 7) tgt = SPEED;
            else              tgt = int'($urandom_range(0, (1 << PWM_W) - 1));
            send_cmd(3'd1);
            speed = tgt[PWM_W-1:0];
            record(12);
            extract_changes(model_duty);
            exp_q.delete();
            model_ramp(model_duty, tgt);
            checks++;
            if (!seq_equal()) begin
                errors++;
                $display("FAIL speed_ramp %0d->%0d seq=%s required %s", model_duty, tgt, q2s(chg_q), q2s(exp_q));
            end
            checks++;
            if (duty_log[11] != tgt || busy_log[11] !== 1'b0 || motor_log[11] !== P_FWD) begin
                errors++;
                $display("FAIL speed_settle duty=%0d busy=%b motor=%b required %0d/0/%b",
                         duty_log[11], busy_log[11], motor_log[11], tgt, P_FWD);
            end
            model_duty = tgt;
            if (it < 2) begin
                record(15);
                cnt = 0;
                foreach (pwm_log[i]) if (pwm_log[i] == 2'b11) cnt++;
                checks++;
                if (cnt !== ((tgt == 0) ? 0 : 15)) begin
                    errors++;
                    $display("FAIL pwm_extreme duty=%0d high=%0d required %0d", tgt, cnt, (tgt == 0) ? 0 : 15);
                end
            end
        end
    endtask

    task automatic test_reversal();
        logic [3:0] run_pat[$];
        int         run_len[$];
        send_cmd(3'd2);
        record(30);
        extract_changes(model_duty);
        exp_q.delete();
        model_ramp(model_duty, 0);
        model_ramp(0, SPEED);
        checks++;
        if (!seq_equal()) begin
            errors++;
            $display("FAIL reversal_duty seq=%s required %s", q2s(chg_q), q2s(exp_q));
        end
        run_pat.push_back(motor_log[0]);
        run_len.push_back(1);
        for (int i = 1; i < motor_log.size(); i++) begin
            if (motor_log[i] == run_pat[run_pat.size()-1]) run_len[run_len.size()-1]++;
            else begin
                run_pat.push_back(motor_log[i]);
                run_len.push_back(1);
            end
        end
        checks++;
        if (run_pat.size() != 3) begin
            errors++;
            $display("FAIL reversal_motor_runs count=%0d required 3", run_pat.size());
        end else if (run_pat[0] !== P_FWD || run_pat[1] !== P_STOP || run_pat[2] !== P_BWD ||
                     run_len[1] != DEAD_CYC) begin
            errors++;
            $display("FAIL reversal_motor %b,%b(x%0d),%b required %b,%b(x%0d),%b",
                     run_pat[0], run_pat[1], run_len[1], run_pat[2], P_FWD, P_STOP, DEAD_CYC, P_BWD);
        end
        checks++;
        if (duty_log[run_len[0]] != 0 || busy_log[run_len[0]] !== 1'b1) begin
            errors++;
            $display("FAIL reversal_dead_entry duty=%0d busy=%b required 0/1",
                     duty_log[run_len[0]], busy_log[run_len[0]]);
        end
        model_duty = SPEED;
    endtask

    task automatic test_overwrite_dead();
        int  n = 0;
        int  first = -1;
        bit  seen_fwd = 1'b0;
        send_cmd(3'd1);
        while (motor !== P_STOP && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (motor !== P_STOP) begin
            errors++;
            $display("FAIL overwrite_reach_dead motor=%b required %b within 40 cycles", motor, P_STOP);
        end
        send_cmd(3'd3);
        record(20);
        foreach (motor_log[i]) begin
            if (motor_log[i] === P_FWD) seen_fwd = 1'b1;
            if (first < 0 && motor_log[i] !== P_STOP) first = i;
        end
        checks++;
        if (seen_fwd || first < 0 || motor_log[(first < 0) ? 0 : first] !== P_LEFT) begin
            errors++;
            $display("FAIL overwrite_dead first_pattern=%b fwd_seen=%0d required %b and no %b",
                     motor_log[(first < 0) ? 0 : first], seen_fwd, P_LEFT, P_FWD);
        end
        checks++;
        if (duty_log[19] != SPEED || motor_log[19] !== P_LEFT) begin
            errors++;
            $display("FAIL overwrite_settle duty=%0d motor=%b required %0d/%b", duty_log[19], motor_log[19], SPEED, P_LEFT);
        end
    endtask

    task automatic test_watchdog();
        int trips[$];
        send_cmd(3'd1);
        record(WDOG_CYC + 40);
        foreach (trip_log[i]) if (trip_log[i] === 1'b1) trips.push_back(i);
        checks++;
        if (motor_log[WDOG_CYC-2] !== P_FWD || duty_log[WDOG_CYC-2] != SPEED) begin
            errors++;
            $display("FAIL wdog_pre motor=%b duty=%0d required %b/%0d", motor_log[WDOG_CYC-2],
                     duty_log[WDOG_CYC-2], P_FWD, SPEED);
        end
`ifdef CMD_WATCHDOG_EN
        checks++;
        if (trips.size() != 1 || trips[0] != WDOG_CYC - 1) begin
            errors++;
            $display("FAIL wdog_pulse at=%s required single pulse at %0d", q2s(trips), WDOG_CYC - 1);
        end
        checks++;
        if (motor_log[WDOG_CYC+39] !== P_STOP || duty_log[WDOG_CYC+39] != 0 || busy_log[WDOG_CYC+39] !== 1'b0) begin
            errors++;
            $display("FAIL wdog_stop motor=%b duty=%0d busy=%b required %b/0/0", motor_log[WDOG_CYC+39],
                     duty_log[WDOG_CYC+39], busy_log[WDOG_CYC+39], P_STOP);
        end
`else
        checks++;
        if (trips.size() != 0) begin
            errors++;
            $display("FAIL wdog_disabled_pulse count=%0d required 0", trips.size());
        end
        checks++;
        if (motor_log[WDOG_CYC+39] !== P_FWD || duty_log[WDOG_CYC+39] != SPEED) begin
            errors++;
            $display("FAIL wdog_disabled_hold motor=%b duty=%0d required %b/%0d", motor_log[WDOG_CYC+39],
                     duty_log[WDOG_CYC+39], P_FWD, SPEED);
        end
`endif
    endtask

    task automatic test_async_reset();
        send_cmd(3'd1);
        record(12);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (motor !== P_STOP || pwm !== 2'b00 || busy !== 1'b0 || dut.duty !== '0) begin
            errors++;
            $display("FAIL async_reset motor=%b pwm=%b busy=%b duty=%0d required 0000/00/0/0",
                     motor, pwm, busy, dut.duty);
        end
        step();
        rst_n = 1'b1;
        record(8);
        checks++;
        if (motor_log[7] !== P_STOP || duty_log[7] != 0 || busy_log[7] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle motor=%b duty=%0d busy=%b required 0000/0/0",
                     motor_log[7], duty_log[7], busy_log[7]);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_invalid();
        test_speed_random();
        test_reversal();
        test_overwrite_dead();
        test_watchdog();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
